imem_loader: RTL and testbench

- Writer side of the instruction-memory interface that the CPU fetch stage reads from.
- Receives a byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes each word into the IM at consecutive byte addresses (stride 2, matching the PC's +2 increment).
- Holds the CPU in reset until the image is fully loaded.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status bundle of imem_loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  // Loader side
  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

  // Stream source / system side
  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a LEN-prefixed byte stream into the instruction memory as 16-bit words, holding the CPU until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
  parameter int unsigned       MAX_WORDS = 128
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK   = 3'd5,
`endif
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_byte_ready;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [DATA_W-1:0]   r_imem_wdata;
  logic                r_cpu_hold;
  logic                r_done;
  logic                r_error;
  logic [CNT_W-1:0]    r_num_words;
  logic [CNT_W-1:0]    r_word_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   r_chk;
`endif

  logic                w_xfer;
  logic                w_len_bad;
  logic                w_last;
  logic [31:0]         w_len_end;

  assign w_xfer    = bus.byte_valid & r_byte_ready;
  // Image must be non-empty, within MAX_WORDS and must not wrap the IM address space
  assign w_len_end = 32'(BASE_ADDR) + (32'(bus.byte_data) << 1);
  assign w_len_bad = (bus.byte_data == '0) ||
                     (32'(bus.byte_data) > MAX_WORDS) ||
                     (w_len_end > (32'd1 << ADDR_W));
  assign w_last    = (({1'b0, r_word_cnt} + (CNT_W+1)'(1)) == {1'b0, r_num_words});

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_LEN;
      S_LEN:   if (w_xfer) w_next = w_len_bad ? S_ERR : S_HI;
      S_HI:    if (w_xfer) w_next = S_LO;
      S_LO:    if (w_xfer) w_next = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_WRITE: w_next = w_last ? S_CHK : S_HI;
      S_CHK:   if (w_xfer) w_next = (bus.byte_data == r_chk) ? S_DONE : S_ERR;
`else
      S_WRITE: w_next = w_last ? S_DONE : S_HI;
`endif
      S_DONE:  if (bus.start) w_next = S_LEN;
      S_ERR:   if (bus.start) w_next = S_LEN;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered status/handshake outputs decoded from the upcoming state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_ready <= 1'b0;
      r_imem_we    <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_byte_ready <= (w_next == S_LEN) || (w_next == S_HI) ||
                      (w_next == S_LO)  || (w_next == S_CHK);
`else
      r_byte_ready <= (w_next == S_LEN) || (w_next == S_HI) || (w_next == S_LO);
`endif
      r_imem_we    <= (w_next == S_WRITE);
      r_cpu_hold   <= (w_next != S_DONE);
      r_done       <= (w_next == S_DONE);
      r_error      <= (w_next == S_ERR);
    end
  end

  // Word assembly, address and word counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_imem_addr  <= BASE_ADDR;
      r_imem_wdata <= '0;
      r_num_words  <= '0;
      r_word_cnt   <= '0;
    end else begin
      case (r_state)
        S_LEN: if (w_xfer && !w_len_bad) begin
          r_num_words <= CNT_W'(bus.byte_data);
          r_word_cnt  <= '0;
          r_imem_addr <= BASE_ADDR;
        end
        S_HI:  if (w_xfer) r_imem_wdata[DATA_W-1 -: BYTE_W] <= bus.byte_data;
        S_LO:  if (w_xfer) r_imem_wdata[BYTE_W-1:0]         <= bus.byte_data;
        S_WRITE: begin
          r_word_cnt <= r_word_cnt + CNT_W'(1);
          if (!w_last) r_imem_addr <= r_imem_addr + ADDR_W'(2);
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over data bytes only, restarted on every entry to LEN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chk <= '0;
    end else if ((r_state != S_LEN) && (w_next == S_LEN)) begin
      r_chk <= '0;
    end else if (((r_state == S_HI) || (r_state == S_LO)) && w_xfer) begin
      r_chk <= r_chk ^ bus.byte_data;
    end
  end
`endif

  assign bus.byte_ready = r_byte_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign bus.cpu_hold   = r_cpu_hold;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected IM writes queued at stimulus time, popped on each imem_we.
module tb_imem_loader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  logic [23:0]  sb[$];
  logic [15:0]  img[0:127];

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(8'h00), .MAX_WORDS(128)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the oldest expected word
  always @(negedge clk) begin
    if (reset && bus.imem_we) begin
      check_eq("ready_in_write", 32'(bus.byte_ready), 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_we", 32'(sb.size()), 32'd1);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        check_eq("we_addr", 32'(bus.imem_addr), 32'(e[23:16]));
        check_eq("we_data", 32'(bus.imem_wdata), 32'(e[15:0]));
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (bus.byte_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    if (!ok) check_eq("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_end();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done || bus.error) begin got = 1'b1; break; end
    end
    if (!got) check_eq("end_timeout", 32'(got), 32'd1);
  endtask

  // Stream a valid n-word image from img[], queueing the expected writes
  task automatic load_image(input int n, input int gap_max);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) sb.push_back({8'(2*i), img[i]});
    send_byte(8'(n), $urandom_range(0, gap_max));
    for (int i = 0; i < n; i++) begin
      send_byte(img[i][15:8], $urandom_range(0, gap_max));
      send_byte(img[i][7:0],  $urandom_range(0, gap_max));
      x = x ^ img[i][15:8] ^ img[i][7:0];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x, $urandom_range(0, gap_max));
`endif
  endtask

  task automatic check_done(input string tag, input logic [7:0] last_addr);
    check_eq({tag, "_done"},     32'(bus.done),      32'd1);
    check_eq({tag, "_hold"},     32'(bus.cpu_hold),  32'd0);
    check_eq({tag, "_error"},    32'(bus.error),     32'd0);
    check_eq({tag, "_addr"},     32'(bus.imem_addr), 32'(last_addr));
    check_eq({tag, "_sb_empty"}, 32'(sb.size()),     32'd0);
  endtask

  task automatic check_err(input string tag);
    check_eq({tag, "_error"},    32'(bus.error),    32'd1);
    check_eq({tag, "_hold"},     32'(bus.cpu_hold), 32'd1);
    check_eq({tag, "_done"},     32'(bus.done),     32'd0);
    check_eq({tag, "_sb_empty"}, 32'(sb.size()),    32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check_eq({tag, "_we"},    32'(bus.imem_we),    32'd0);
    check_eq({tag, "_addr"},  32'(bus.imem_addr),  32'd0);
    check_eq({tag, "_wdata"}, 32'(bus.imem_wdata), 32'd0);
    check_eq({tag, "_hold"},  32'(bus.cpu_hold),   32'd1);
    check_eq({tag, "_done"},  32'(bus.done),       32'd0);
    check_eq({tag, "_error"}, 32'(bus.error),      32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_ready", 32'(bus.byte_ready), 32'd0);

    // Basic 2-word image, back-to-back bytes
    img[0] = 16'h1234; img[1] = 16'hABCD;
    pulse_start();
    load_image(2, 0);
    wait_end();
    check_done("two", 8'h02);

    // Zero length, then recovery with a 1-word image
    pulse_start();
    send_byte(8'h00, 0);
    wait_end();
    check_err("len0");
    img[0] = 16'hBEEF;
    pulse_start();
    load_image(1, 0);
    wait_end();
    check_done("one", 8'h00);

    // Over MAX_WORDS
    pulse_start();
    send_byte(8'h81, 0);
    wait_end();
    check_err("len129");

    // 3-word image, gap-free then with random valid gaps
    img[0] = 16'hA55A; img[1] = 16'h0F0F; img[2] = 16'hC3E1;
    pulse_start();
    load_image(3, 0);
    wait_end();
    check_done("three", 8'h04);
    pulse_start();
    load_image(3, 5);
    wait_end();
    check_done("gaps", 8'h04);

    // Largest image: exactly fills the 256-byte IM
    for (int i = 0; i < 128; i++) img[i] = 16'($urandom);
    pulse_start();
    load_image(128, 0);
    wait_end();
    check_done("max", 8'hFE);

    // Reset after the HI byte of word 2
    img[0] = 16'h1122; img[1] = 16'h3344;
    pulse_start();
    sb.push_back({8'h00, 16'h1122});
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    check_eq("midrst_sb_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulse_start();
    load_image(2, 2);
    wait_end();
    check_done("after_rst", 8'h02);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Correct and wrong checksum bytes
    pulse_start();
    sb.push_back({8'h00, 16'h1234});
    send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h26, 0);
    wait_end();
    check_done("chk_ok", 8'h00);
    pulse_start();
    sb.push_back({8'h00, 16'h1234});
    send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h00, 0);
    wait_end();
    check_err("chk_bad");
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
